// File: rtl/sw_pkg.sv
// sw_pkg: shared definitions for the Smith-Waterman input stage.
//   - UART register byte offsets on the Avalon-MM slave (RX, TX, STATUS)
//   - STATUS bit positions for RX_OK / TX_OK
//   - packed sequence width and default frame geometry
//   - loader FSM state encoding
package sw_pkg;

    localparam logic [4:0] RX_BASE     = 5'd0;
    localparam logic [4:0] TX_BASE     = 5'd4;
    localparam logic [4:0] STATUS_BASE = 5'd8;

    localparam int RX_OK_BIT = 7;
    localparam int TX_OK_BIT = 6;

    localparam int SEQ_BITS       = 256;
    localparam int REF_BYTES_DEF  = 32;
    localparam int READ_BYTES_DEF = 32;

    // S_POLL_TX / S_WRITE_TX are only reachable when echo is compiled in.
    typedef enum logic [2:0] {
        S_POLL_RX  = 3'd0,
        S_READ_RX  = 3'd1,
        S_POLL_TX  = 3'd2,
        S_WRITE_TX = 3'd3,
        S_PRESENT  = 3'd4
    } loader_state_t;

endpackage

// File: rtl/avm_uart_if.sv
// avm_uart_if: Avalon-MM master request holder for the UART slave.
//   A request is loaded with start_read/start_write and then held constant
//   (address, read/write, writedata) until a cycle with the request high and
//   avm_waitrequest low. That cycle raises done and rdata carries the low
//   byte of avm_readdata. A new start in the done cycle chains the next
//   request with no idle cycle; without one the request drops.
//   Out of reset a STATUS read is already pending.
// Ports:
//   clk, rst_n              clock, async active-low reset
//   start_read, start_write launch a request (read wins if both)
//   addr, wdata             address / byte for the launched request
//   done, rdata             completion pulse and read byte
//   avm_*                   Avalon-MM master signals
module avm_uart_if
    import sw_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_read,
    input  logic        start_write,
    input  logic [4:0]  addr,
    input  logic [7:0]  wdata,
    output logic        done,
    output logic [7:0]  rdata,
    output logic [4:0]  avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    output logic        avm_write,
    output logic [31:0] avm_writedata,
    input  logic        avm_waitrequest
);

    // Only the low byte of readdata carries RX data and STATUS flags.
    logic unused_readdata;
    assign unused_readdata = ^avm_readdata[31:8];

    assign done  = (avm_read || avm_write) && !avm_waitrequest;
    assign rdata = avm_readdata[7:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            avm_read      <= 1'b1;
            avm_write     <= 1'b0;
            avm_address   <= STATUS_BASE;
            avm_writedata <= '0;
        end else if (start_read) begin
            avm_read      <= 1'b1;
            avm_write     <= 1'b0;
            avm_address   <= addr;
            avm_writedata <= '0;
        end else if (start_write) begin
            avm_read      <= 1'b0;
            avm_write     <= 1'b1;
            avm_address   <= addr;
            avm_writedata <= {24'h0, wdata};
        end else if (done) begin
            avm_read  <= 1'b0;
            avm_write <= 1'b0;
        end
    end

endmodule

// File: rtl/sw_seq_loader.sv
// sw_seq_loader: polls the UART, pulls REF_BYTES+READ_BYTES bytes from RX
// and packs them MSB-first into o_sequence_ref / o_sequence_read, then
// offers the frame to the SW core.
// Handshake: o_valid stays high with the frame stable until a cycle with
// o_valid && i_ready; that cycle is the transfer and the next frame starts
// loading right after it (the consumer must latch the sequences then).
// Optional feature macro: SEQ_LOADER_ECHO_EN -- echo every RX byte to TX
// (after a STATUS poll showing TX_OK) before polling RX again. Without it
// avm_write is constantly 0.
// Ports:
//   avm_clk, avm_rst_n   clock, async active-low reset
//   avm_*                Avalon-MM master to the UART
//   o_valid, i_ready     frame handshake
//   o_sequence_ref/read  packed sequences, first byte in [255:248]
//   o_busy               high from first byte accepted until handshake
//   dbg_state, dbg_cnt   FSM state and byte counter for observation
module sw_seq_loader
    import sw_pkg::*;
#(
    parameter int REF_BYTES  = REF_BYTES_DEF,
    parameter int READ_BYTES = READ_BYTES_DEF
) (
    input  logic                avm_clk,
    input  logic                avm_rst_n,
    output logic [4:0]          avm_address,
    output logic                avm_read,
    input  logic [31:0]         avm_readdata,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic                avm_waitrequest,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SEQ_BITS-1:0] o_sequence_ref,
    output logic [SEQ_BITS-1:0] o_sequence_read,
    output logic                o_busy,
    output loader_state_t       dbg_state,
    output logic [6:0]          dbg_cnt
);

    localparam logic [6:0] TOTAL = 7'(REF_BYTES + READ_BYTES);

    loader_state_t state, state_n;
    logic [6:0]    cnt;
    logic          start_read, start_write, done;
    logic [4:0]    req_addr;
    logic [7:0]    rx_byte, tx_byte;
    logic          capture, clear;
    logic          last_rx;

    avm_uart_if u_avm (
        .clk             (avm_clk),
        .rst_n           (avm_rst_n),
        .start_read      (start_read),
        .start_write     (start_write),
        .addr            (req_addr),
        .wdata           (tx_byte),
        .done            (done),
        .rdata           (rx_byte),
        .avm_address     (avm_address),
        .avm_read        (avm_read),
        .avm_readdata    (avm_readdata),
        .avm_write       (avm_write),
        .avm_writedata   (avm_writedata),
        .avm_waitrequest (avm_waitrequest)
    );

    assign last_rx   = (cnt == TOTAL - 7'd1);
    assign o_valid   = (state == S_PRESENT);
    assign o_busy    = (cnt != 7'd0);
    assign dbg_state = state;
    assign dbg_cnt   = cnt;

`ifdef SEQ_LOADER_ECHO_EN
    logic [7:0] held_byte;

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            held_byte <= 8'h00;
        end else if (capture) begin
            held_byte <= rx_byte;
        end
    end

    assign tx_byte = held_byte;
`else
    assign tx_byte = 8'h00;
`endif

    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            state <= S_POLL_RX;
        end else begin
            state <= state_n;
        end
    end

    // Every completion either chains the next request in the same cycle or
    // drops the request; that is what gives 2 (4 with echo) cycles per byte.
    always_comb begin
        state_n     = state;
        start_read  = 1'b0;
        start_write = 1'b0;
        req_addr    = STATUS_BASE;
        capture     = 1'b0;
        clear       = 1'b0;
        case (state)
            S_POLL_RX: begin
                if (done) begin
                    start_read = 1'b1;
                    if (rx_byte[RX_OK_BIT]) begin
                        req_addr = RX_BASE;
                        state_n  = S_READ_RX;
                    end
                end
            end
            S_READ_RX: begin
                if (done) begin
                    capture = 1'b1;
`ifdef SEQ_LOADER_ECHO_EN
                    start_read = 1'b1;
                    state_n    = S_POLL_TX;
`else
                    if (last_rx) begin
                        state_n = S_PRESENT;
                    end else begin
                        start_read = 1'b1;
                        state_n    = S_POLL_RX;
                    end
`endif
                end
            end
`ifdef SEQ_LOADER_ECHO_EN
            S_POLL_TX: begin
                if (done) begin
                    if (rx_byte[TX_OK_BIT]) begin
                        start_write = 1'b1;
                        req_addr    = TX_BASE;
                        state_n     = S_WRITE_TX;
                    end else begin
                        start_read = 1'b1;
                    end
                end
            end
            S_WRITE_TX: begin
                if (done) begin
                    // cnt was already advanced when the byte was read.
                    if (cnt == TOTAL) begin
                        state_n = S_PRESENT;
                    end else begin
                        start_read = 1'b1;
                        state_n    = S_POLL_RX;
                    end
                end
            end
`endif
            S_PRESENT: begin
                if (i_ready) begin
                    clear      = 1'b1;
                    start_read = 1'b1;
                    state_n    = S_POLL_RX;
                end
            end
            default: begin
                state_n = S_POLL_RX;
            end
        endcase
    end

    // Byte i of the frame lands MSB-first; constant selects per byte slot.
    always_ff @(posedge avm_clk or negedge avm_rst_n) begin
        if (!avm_rst_n) begin
            cnt             <= 7'd0;
            o_sequence_ref  <= '0;
            o_sequence_read <= '0;
        end else if (clear) begin
            cnt <= 7'd0;
        end else if (capture) begin
            cnt <= cnt + 7'd1;
            for (int i = 0; i < REF_BYTES; i++) begin
                if (cnt == 7'(i)) begin
                    o_sequence_ref[SEQ_BITS-1-8*i -: 8] <= rx_byte;
                end
            end
            for (int i = 0; i < READ_BYTES; i++) begin
                if (cnt == 7'(REF_BYTES + i)) begin
                    o_sequence_read[SEQ_BITS-1-8*i -: 8] <= rx_byte;
                end
            end
        end
    end

endmodule
